// File: rtl/conv_seq_ctrl_pkg.sv
// conv_pkg -- shared types and default sizes for the 1-D convolution sequencer.
//
// Contents:
//   X_SIZE_D / F_SIZE_D : default frame sizes (8 samples, 4 taps)
//   conv_state_t        : sequencer state encoding (IDLE, LOAD, MAC, OUT)
//   conv_clog2          : ceiling log2 helper, at least 1, usable for counter widths
//
// Optional feature macro used elsewhere in this slice: CONV_STALL_CNT_EN

package conv_pkg;

    localparam int X_SIZE_D = 8;
    localparam int F_SIZE_D = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        OUT  = 2'd3
    } conv_state_t;

    // Width helper that never returns 0, so a size of 1 still gets a 1-bit field.
    function automatic int conv_clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// conv_seq_ctrl_if -- control bus between the convolution sequencer and its datapath/streams.
//
// Parameters:
//   X_AW, F_AW : x / f memory address widths
//
// Signals:
//   s_valid_x / s_ready_x : x input stream handshake
//   s_valid_f / s_ready_f : f input stream handshake
//   wr_en_x, addr_x       : x memory write enable and shared read/write address
//   wr_en_f, addr_f       : f memory write enable and shared read/write address
//   en_acc, clr_acc       : accumulator accumulate / clear (clear wins)
//   m_valid_y / m_ready_y : result output handshake
//   conv_done             : one-cycle frame-complete pulse
//   stall_cnt             : output stall cycle counter (only with CONV_STALL_CNT_EN)
//
// Modports:
//   master : the sequencer side (drives control, reads valids and m_ready_y)
//   slave  : the datapath/environment side

interface conv_seq_ctrl_if #(
    parameter int X_AW = 3,
    parameter int F_AW = 2
);

    logic            s_valid_x;
    logic            s_ready_x;
    logic            s_valid_f;
    logic            s_ready_f;
    logic            wr_en_x;
    logic [X_AW-1:0] addr_x;
    logic            wr_en_f;
    logic [F_AW-1:0] addr_f;
    logic            en_acc;
    logic            clr_acc;
    logic            m_valid_y;
    logic            m_ready_y;
    logic            conv_done;
`ifdef CONV_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

`ifdef CONV_STALL_CNT_EN
    modport master (
        input  s_valid_x, s_valid_f, m_ready_y,
        output s_ready_x, s_ready_f, wr_en_x, addr_x, wr_en_f, addr_f,
               en_acc, clr_acc, m_valid_y, conv_done, stall_cnt
    );

    modport slave (
        output s_valid_x, s_valid_f, m_ready_y,
        input  s_ready_x, s_ready_f, wr_en_x, addr_x, wr_en_f, addr_f,
               en_acc, clr_acc, m_valid_y, conv_done, stall_cnt
    );
`else
    modport master (
        input  s_valid_x, s_valid_f, m_ready_y,
        output s_ready_x, s_ready_f, wr_en_x, addr_x, wr_en_f, addr_f,
               en_acc, clr_acc, m_valid_y, conv_done
    );

    modport slave (
        output s_valid_x, s_valid_f, m_ready_y,
        input  s_ready_x, s_ready_f, wr_en_x, addr_x, wr_en_f, addr_f,
               en_acc, clr_acc, m_valid_y, conv_done
    );
`endif

endinterface

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl -- sequencer for the X_SIZE x F_SIZE 1-D convolution datapath.
//
// Loads an x frame and an f frame from two independent valid/ready streams into
// their memories, then for each of the Y_SIZE outputs clears the accumulator,
// walks the taps (memories have a 1-cycle read latency) and presents the result
// on a valid/ready handshake. No data passes through this block; it only emits
// memory addresses/write enables and accumulator controls.
//
// Ports:
//   clk   : clock, all flops on rising edge
//   reset : asynchronous, active-high reset
//   bus   : conv_seq_ctrl_if.master (stream handshakes, memory and accumulator controls)
//
// Optional feature: define CONV_STALL_CNT_EN to add bus.stall_cnt, a saturating
// count of cycles where the result is valid but not accepted, cleared on each
// LOAD->MAC transition.

module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_D,
    parameter int F_SIZE = F_SIZE_D
) (
    input  logic            clk,
    input  logic            reset,
    conv_seq_ctrl_if.master bus
);

    localparam int Y_SIZE = X_SIZE - F_SIZE + 1;
    localparam int X_AW   = conv_clog2(X_SIZE);
    localparam int F_AW   = conv_clog2(F_SIZE);
    localparam int XC_W   = conv_clog2(X_SIZE + 1);
    localparam int FC_W   = conv_clog2(F_SIZE + 1);
    localparam int K_W    = conv_clog2(F_SIZE + 1);
    localparam int N_W    = conv_clog2(Y_SIZE);

    conv_state_t     state_q;
    conv_state_t     state_d;

    logic [XC_W-1:0] x_cnt_q;
    logic [FC_W-1:0] f_cnt_q;
    logic [K_W-1:0]  k_q;
    logic [N_W-1:0]  n_q;
    logic            done_q;

    logic            x_full;
    logic            f_full;
    logic            x_take;
    logic            f_take;
    logic            y_handshake;
    logic            last_output;
    logic            last_tap;

    logic            s_ready_x_c;
    logic            s_ready_f_c;
    logic            wr_en_x_c;
    logic            wr_en_f_c;
    logic [X_AW-1:0] addr_x_c;
    logic [F_AW-1:0] addr_f_c;
    logic            en_acc_c;
    logic            clr_acc_c;
    logic            m_valid_y_c;

    // Status decodes, all derived from registered state so the ready outputs
    // never depend combinationally on the incoming valids.
    assign x_full      = (x_cnt_q == XC_W'(X_SIZE));
    assign f_full      = (f_cnt_q == FC_W'(F_SIZE));
    assign x_take      = (state_q == LOAD) && !x_full && bus.s_valid_x;
    assign f_take      = (state_q == LOAD) && !f_full && bus.s_valid_f;
    assign y_handshake = (state_q == OUT) && bus.m_ready_y;
    assign last_output = (n_q == N_W'(Y_SIZE - 1));
    assign last_tap    = (k_q == K_W'(F_SIZE));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: LOAD waits for both frames, MAC runs F_SIZE+1 cycles,
    // OUT waits for the consumer and either starts the next output or a new frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (x_full && f_full) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.m_ready_y) begin
                    state_d = last_output ? LOAD : MAC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame/tap/output counters and the frame-complete flag. Counts are cleared
    // on the final output handshake so the streams are ready again in the very
    // cycle conv_done is shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt_q <= '0;
            f_cnt_q <= '0;
            k_q     <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= y_handshake && last_output;
            unique case (state_q)
                IDLE: begin
                    x_cnt_q <= '0;
                    f_cnt_q <= '0;
                    k_q     <= '0;
                    n_q     <= '0;
                end
                LOAD: begin
                    if (x_take) begin
                        x_cnt_q <= x_cnt_q + XC_W'(1);
                    end
                    if (f_take) begin
                        f_cnt_q <= f_cnt_q + FC_W'(1);
                    end
                    k_q <= '0;
                end
                MAC: begin
                    k_q <= last_tap ? '0 : (k_q + K_W'(1));
                end
                OUT: begin
                    if (y_handshake) begin
                        if (last_output) begin
                            x_cnt_q <= '0;
                            f_cnt_q <= '0;
                            n_q     <= '0;
                        end else begin
                            n_q <= n_q + N_W'(1);
                        end
                    end
                end
                default: begin
                    k_q <= '0;
                end
            endcase
        end
    end

    // Output decode. In LOAD the memory addresses carry the write counts; in MAC
    // they carry the read address for tap k, and the accumulator is enabled one
    // cycle later to match the 1-cycle memory read latency.
    always_comb begin
        s_ready_x_c = 1'b0;
        s_ready_f_c = 1'b0;
        wr_en_x_c   = 1'b0;
        wr_en_f_c   = 1'b0;
        addr_x_c    = '0;
        addr_f_c    = '0;
        en_acc_c    = 1'b0;
        clr_acc_c   = 1'b0;
        m_valid_y_c = 1'b0;
        unique case (state_q)
            LOAD: begin
                s_ready_x_c = !x_full;
                s_ready_f_c = !f_full;
                wr_en_x_c   = x_take;
                wr_en_f_c   = f_take;
                addr_x_c    = x_cnt_q[X_AW-1:0];
                addr_f_c    = f_cnt_q[F_AW-1:0];
            end
            MAC: begin
                clr_acc_c = (k_q == '0);
                en_acc_c  = (k_q != '0);
                if (k_q < K_W'(F_SIZE)) begin
                    addr_x_c = X_AW'(n_q) + X_AW'(k_q);
                    addr_f_c = F_AW'(k_q);
                end
            end
            OUT: begin
                m_valid_y_c = 1'b1;
            end
            default: begin
                m_valid_y_c = 1'b0;
            end
        endcase
    end

    assign bus.s_ready_x = s_ready_x_c;
    assign bus.s_ready_f = s_ready_f_c;
    assign bus.wr_en_x   = wr_en_x_c;
    assign bus.wr_en_f   = wr_en_f_c;
    assign bus.addr_x    = addr_x_c;
    assign bus.addr_f    = addr_f_c;
    assign bus.en_acc    = en_acc_c;
    assign bus.clr_acc   = clr_acc_c;
    assign bus.m_valid_y = m_valid_y_c;
    assign bus.conv_done = done_q;

`ifdef CONV_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of back-pressured output cycles, restarted per frame
    // when computation begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == LOAD) && (state_d == MAC)) begin
            stall_q <= '0;
        end else if ((state_q == OUT) && !bus.m_ready_y && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl -- self-checking bench for conv_seq_ctrl.
//
// Plays the role of the datapath (x/f memories with 1-cycle read, MAC accumulator)
// and the stream source/consumer. Results are compared with convolution sums
// computed directly from the frame data; control timing is compared with a
// per-cycle phase model. Honours CONV_STALL_CNT_EN.

module tb_conv_seq_ctrl;

    typedef enum int {P_IDLE, P_LOAD, P_MAC, P_OUT} phase_t;

    logic clk;
    logic reset;

    conv_seq_ctrl_if #(.X_AW(3), .F_AW(2)) bus ();

    conv_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Frame data and stream payloads.
    int x_src [8];
    int f_src [4];
    int x_data;
    int f_data;

    // Datapath stand-in.
    int x_mem [8];
    int f_mem [4];
    int rd_x;
    int rd_f;
    int acc;
    int xw_q [$];
    int fw_q [$];

    // Reference model.
    phase_t ph;
    int xa, fa, n, k;
    bit done_exp;
    int stall_exp;
    int frames_done;

    // Stimulus knobs.
    int vx_pct, vf_pct;
    int rdy_mode;
    int stall_n, stall_left;

    always @(posedge clk) begin
        if (bus.wr_en_x) begin
            x_mem[bus.addr_x] <= x_data;
            xw_q.push_back(int'(bus.addr_x));
        end
        if (bus.wr_en_f) begin
            f_mem[bus.addr_f] <= f_data;
            fw_q.push_back(int'(bus.addr_f));
        end
        rd_x <= x_mem[bus.addr_x];
        rd_f <= f_mem[bus.addr_f];
        if (bus.clr_acc) begin
            acc <= 0;
        end else if (bus.en_acc) begin
            acc <= acc + rd_x * rd_f;
        end
    end

    function automatic int ref_y(input int idx);
        int s;
        s = 0;
        for (int t = 0; t < 4; t++) begin
            s += x_src[idx + t] * f_src[t];
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        ph = P_IDLE;
        xa = 0;
        fa = 0;
        n = 0;
        k = 0;
        done_exp = 0;
        stall_exp = 0;
    endtask

    // Advance the reference by one clock using the inputs the DUT just sampled.
    task automatic modelUpdate();
        bit nd;
        nd = 0;
        if (reset) begin
            modelReset();
            return;
        end
        case (ph)
            P_IDLE: ph = P_LOAD;
            P_LOAD: begin
                if (xa == 8 && fa == 4) begin
                    ph = P_MAC;
                    k = 0;
                    stall_exp = 0;
                end else begin
                    if (bus.s_valid_x && xa < 8) xa++;
                    if (bus.s_valid_f && fa < 4) fa++;
                end
            end
            P_MAC: begin
                if (k == 4) ph = P_OUT;
                else k++;
            end
            P_OUT: begin
                if (!bus.m_ready_y) begin
                    if (stall_exp < 65535) stall_exp++;
                end else if (n < 4) begin
                    n++;
                    ph = P_MAC;
                    k = 0;
                end else begin
                    ph = P_LOAD;
                    xa = 0;
                    fa = 0;
                    n = 0;
                    nd = 1;
                    frames_done++;
                end
            end
            default: ph = P_IDLE;
        endcase
        done_exp = nd;
    endtask

    task automatic checkCycle();
        checkOutput("s_ready_x", bus.s_ready_x, 32'(ph == P_LOAD && xa < 8));
        checkOutput("s_ready_f", bus.s_ready_f, 32'(ph == P_LOAD && fa < 4));
        checkOutput("wr_en_x", bus.wr_en_x, 32'(ph == P_LOAD && xa < 8 && bus.s_valid_x));
        checkOutput("wr_en_f", bus.wr_en_f, 32'(ph == P_LOAD && fa < 4 && bus.s_valid_f));
        checkOutput("m_valid_y", bus.m_valid_y, 32'(ph == P_OUT));
        checkOutput("conv_done", bus.conv_done, 32'(done_exp));
        checkOutput("clr_acc", bus.clr_acc, 32'(ph == P_MAC && k == 0));
        checkOutput("en_acc", bus.en_acc, 32'(ph == P_MAC && k >= 1));
        if (ph == P_LOAD) begin
            checkOutput("addr_x_load", bus.addr_x, 32'(xa % 8));
            checkOutput("addr_f_load", bus.addr_f, 32'(fa % 4));
        end
        if (ph == P_MAC && k < 4) begin
            checkOutput("addr_x_mac", bus.addr_x, 32'(n + k));
            checkOutput("addr_f_mac", bus.addr_f, 32'(k));
        end
        if (ph == P_OUT) begin
            checkOutput("y_value", acc, ref_y(n));
        end
`ifdef CONV_STALL_CNT_EN
        checkOutput("stall_cnt", bus.stall_cnt, 32'(stall_exp));
`endif
    endtask

    task automatic applyStimulus();
        bus.s_valid_x = ($urandom_range(0, 99) < vx_pct);
        bus.s_valid_f = ($urandom_range(0, 99) < vf_pct);
        x_data = (xa < 8) ? x_src[xa] : 0;
        f_data = (fa < 4) ? f_src[fa] : 0;
        case (rdy_mode)
            0: bus.m_ready_y = 1'b1;
            1: bus.m_ready_y = ($urandom_range(0, 3) != 0);
            default: begin
                if (ph == P_OUT && n == stall_n && stall_left > 0) begin
                    bus.m_ready_y = 1'b0;
                    stall_left--;
                end else begin
                    bus.m_ready_y = 1'b1;
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkCycle();
        applyStimulus();
    endtask

    // 0: ramp x, unit f; 1: ramp x, f = 1,-1,0,0; otherwise random values.
    task automatic setFrame(input int kind);
        for (int i = 0; i < 8; i++) begin
            x_src[i] = (kind < 2) ? (i + 1) : (int'($urandom_range(0, 100)) - 50);
        end
        for (int i = 0; i < 4; i++) begin
            case (kind)
                0: f_src[i] = 1;
                1: f_src[i] = (i == 0) ? 1 : ((i == 1) ? -1 : 0);
                default: f_src[i] = int'($urandom_range(0, 20)) - 10;
            endcase
        end
        xw_q.delete();
        fw_q.delete();
    endtask

    task automatic runFrame(input string tag);
        int start;
        int cyc;
        start = frames_done;
        cyc = 0;
        applyStimulus();
        while (frames_done == start && cyc < 600) begin
            step();
            cyc++;
        end
        checkOutput({tag, "_completed"}, frames_done - start, 1);
        checkOutput({tag, "_x_writes"}, xw_q.size(), 8);
        checkOutput({tag, "_f_writes"}, fw_q.size(), 4);
        for (int i = 0; i < 8; i++) begin
            checkOutput({tag, "_x_waddr"}, (i < xw_q.size()) ? xw_q[i] : -1, i);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, "_f_waddr"}, (i < fw_q.size()) ? fw_q[i] : -1, i);
        end
        checkOutput({tag, "_ready_x_in_done"}, bus.s_ready_x, 1);
        checkOutput({tag, "_ready_f_in_done"}, bus.s_ready_f, 1);
    endtask

    initial begin
        int cyc;
        bit found;
        checks = 0;
        failures = 0;
        frames_done = 0;
        acc = 0;
        rd_x = 0;
        rd_f = 0;
        for (int i = 0; i < 8; i++) x_mem[i] = 0;
        for (int i = 0; i < 4; i++) f_mem[i] = 0;
        reset = 1'b1;
        vx_pct = 100;
        vf_pct = 100;
        rdy_mode = 0;
        stall_n = 0;
        stall_left = 0;
        modelReset();
        setFrame(0);
        applyStimulus();
        repeat (3) step();
        reset = 1'b0;

        $display("[TB] frame 1: ramp x, unit taps, full throughput");
        runFrame("f1");

        $display("[TB] frame 2: back-to-back, taps 1,-1,0,0");
        setFrame(1);
        runFrame("f2");

        $display("[TB] frame 3: random data, random valid gaps and ready");
        setFrame(2);
        vx_pct = 40;
        vf_pct = 30;
        rdy_mode = 1;
        runFrame("f3");

        $display("[TB] frame 4: consumer stalls 10 cycles at output 2");
        setFrame(2);
        vx_pct = 70;
        vf_pct = 60;
        rdy_mode = 2;
        stall_n = 2;
        stall_left = 10;
        runFrame("f4");

        $display("[TB] frame 5: reset during MAC of output 3");
        setFrame(2);
        rdy_mode = 0;
        applyStimulus();
        found = 0;
        cyc = 0;
        while (!found && cyc < 600) begin
            step();
            cyc++;
            found = (ph == P_MAC && n == 3 && k == 2);
        end
        checkOutput("reached_mac_out3", found, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_m_valid_y", bus.m_valid_y, 0);
        checkOutput("rst_en_acc", bus.en_acc, 0);
        checkOutput("rst_clr_acc", bus.clr_acc, 0);
        checkOutput("rst_addr_x", bus.addr_x, 0);
        checkOutput("rst_addr_f", bus.addr_f, 0);
        checkOutput("rst_s_ready_x", bus.s_ready_x, 0);
        checkOutput("rst_s_ready_f", bus.s_ready_f, 0);
        checkOutput("rst_conv_done", bus.conv_done, 0);
        modelReset();
        repeat (2) step();
        reset = 1'b0;
        setFrame(2);
        vx_pct = 80;
        vf_pct = 80;
        runFrame("f6");

`ifdef CONV_STALL_CNT_EN
        $display("[TB] frame 7: 7 stall cycles at output 0");
        setFrame(2);
        rdy_mode = 2;
        stall_n = 0;
        stall_left = 7;
        runFrame("f7");
        checkOutput("stall_cnt_total", bus.stall_cnt, 7);
        setFrame(2);
        rdy_mode = 0;
        runFrame("f8");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
